// File: rtl/seq_mult_16bit_pkg.sv
// Shared state encoding and default width for the sequential shift-and-add multiplier.
package seq_mult_16bit_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult_16bit_cla.sv
// 16-bit two-level carry-lookahead adder: 4-bit groups with per-group generate/propagate.
module seq_mult_16bit_cla #(
  parameter int WIDTH = 16,
  parameter int GRP_W = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NUM_GRP = WIDTH / GRP_W;

  logic [NUM_GRP-1:0][GRP_W-1:0] g_bit, p_bit, c_bit;
  logic [NUM_GRP-1:0]            g_grp, p_grp;
  logic [NUM_GRP:0]              c_grp;

  for (genvar gi = 0; gi < NUM_GRP; gi++) begin : g_grp_blk
    assign g_bit[gi] = a[gi*GRP_W +: GRP_W] & b[gi*GRP_W +: GRP_W];
    assign p_bit[gi] = a[gi*GRP_W +: GRP_W] ^ b[gi*GRP_W +: GRP_W];

    always_comb begin
      g_grp[gi] = 1'b0;
      p_grp[gi] = 1'b1;
      for (int i = 0; i < GRP_W; i++) begin
        g_grp[gi] = g_bit[gi][i] | (p_bit[gi][i] & g_grp[gi]);
        p_grp[gi] = p_grp[gi] & p_bit[gi][i];
      end
    end

    // Bit carries inside a group only depend on the group's incoming lookahead carry.
    always_comb begin
      c_bit[gi][0] = c_grp[gi];
      for (int i = 1; i < GRP_W; i++)
        c_bit[gi][i] = g_bit[gi][i-1] | (p_bit[gi][i-1] & c_bit[gi][i-1]);
    end

    assign sum[gi*GRP_W +: GRP_W] = p_bit[gi] ^ c_bit[gi];
  end

  always_comb begin
    c_grp[0] = cin;
    for (int j = 0; j < NUM_GRP; j++)
      c_grp[j+1] = g_grp[j] | (p_grp[j] & c_grp[j]);
  end

  assign cout = c_grp[NUM_GRP];

endmodule

// File: rtl/seq_mult_16bit.sv
// Unsigned shift-and-add multiplier: one add/shift per clock, registered product, one-cycle done.
module seq_mult_16bit
  import seq_mult_16bit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  state_t state, state_nxt;

  logic [WIDTH-1:0] m_q, p_q, q_q;
  logic             c_q;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [WIDTH:0]   hi;
  logic [WIDTH-1:0] p_nxt, q_nxt;
  logic             load, step, last;

  seq_mult_16bit_cla #(.WIDTH(WIDTH)) u_add (
    .a    (p_q),
    .b    (m_q),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // c_q holds the bit shifted out above P, which is always zero after a shift.
  assign hi    = q_q[0] ? {cout, sum} : {c_q, p_q};
  assign p_nxt = hi[WIDTH:1];
  assign q_nxt = {hi[0], q_q[WIDTH-1:1]};
  assign last  = (cnt == CNT_W'(WIDTH - 1));
  assign busy  = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: if (start) begin
        load      = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        load      = start;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q     <= '0;
      p_q     <= '0;
      q_q     <= '0;
      c_q     <= 1'b0;
      cnt     <= '0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      if (load) begin
        m_q <= A;
        q_q <= B;
        p_q <= '0;
        c_q <= 1'b0;
        cnt <= '0;
      end else if (step) begin
        c_q <= 1'b0;
        p_q <= p_nxt;
        q_q <= q_nxt;
        cnt <= cnt + 1'b1;
        if (last) begin
          product <= {p_nxt, q_nxt};
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_mult_16bit.sv
// Directed and random checks of seq_mult_16bit against plain integer multiplication.
module tb_seq_mult_16bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic        busy, done;
  logic [31:0] product;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_prod = '0;

  always #5 clk = ~clk;

  seq_mult_16bit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge: drive start for one cycle, end at the first RUN negedge.
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input string tag);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy after start"}, 32'(busy), 32'd1);
    chk({tag, " done after start"}, 32'(done), 32'd0);
  endtask

  // n0 = RUN cycles already elapsed past the first RUN negedge.
  task automatic wait_done(input logic [31:0] exp, input int n0, input string tag);
    int n = n0;
    logic held = 1'b1;
    while (!done && n < 40) begin
      if (product !== model_prod) held = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'd16);
    chk({tag, " product held"}, 32'(held), 32'd1);
    chk({tag, " product"}, product, exp);
    chk({tag, " busy in done"}, 32'(busy), 32'd0);
    model_prod = exp;
  endtask

  task automatic settle(input string tag);
    @(negedge clk);
    chk({tag, " done pulse width"}, 32'(done), 32'd0);
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
  endtask

  task automatic op(input logic [15:0] a, input logic [15:0] b, input string tag);
    launch(a, b, tag);
    wait_done(32'(a) * 32'(b), 0, tag);
    settle(tag);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset product", product, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    op(16'd0, 16'd0, "zero");
    op(16'd40000, 16'd900, "40000x900");
    chk("40000x900 const", model_prod, 32'h02255100);
    op(16'd25937, 16'd50000, "carry");
    chk("carry const", model_prod, 32'h4D4C5C50);

    // Back-to-back: start accepted in the DONE cycle.
    launch(16'hFFFF, 16'hFFFF, "max");
    wait_done(32'hFFFE0001, 0, "max");
    launch(16'd3, 16'd5, "b2b");
    wait_done(32'h0000000F, 0, "b2b");
    settle("b2b");

    // Start and operand changes during RUN are ignored.
    launch(16'd1000, 16'd1000, "ignore");
    repeat (4) @(negedge clk);
    A = 16'd2; B = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(32'h000F4240, 5, "ignore");
    settle("ignore");

    // Async reset mid-RUN discards the operation.
    launch(16'd123, 16'd456, "rst");
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst product", product, 32'd0);
    model_prod = '0;
    @(negedge clk);
    rst = 1'b0;
    begin
      logic saw = 1'b0;
      repeat (20) begin
        @(negedge clk);
        if (done) saw = 1'b1;
      end
      chk("rst no done", 32'(saw), 32'd0);
    end
    op(16'd7, 16'd6, "after rst");

    // Random operands, sometimes chained back-to-back from DONE.
    for (int i = 0; i < 10; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 3 == 0) ra = 16'hFFFF - 16'($urandom_range(0, 3));
      launch(ra, rb, "rand");
      wait_done(32'(ra) * 32'(rb), 0, "rand");
      if ($urandom_range(0, 1) == 0) settle("rand");
    end
    settle("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mult_16bit.md
Name: seq_mult_16bit

Overview:
Sequential unsigned shift-and-add multiplier built around the team's 16-bit carry-lookahead adder. It takes two WIDTH-bit operands on a start pulse and performs one add/shift iteration per clock. It returns a 2*WIDTH-bit product with a one-cycle done pulse. It sits downstream of operand registers and feeds the datapath result bus; it is the first sequential consumer of the CLA adder.

Parameters:
WIDTH, 16, operand width; the adder instance is WIDTH bits wide (only 16 is supported by the current adder).
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only in IDLE or DONE.
A  input  WIDTH  multiplicand, latched on accepted start.
B  input  WIDTH  multiplier, latched on accepted start.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse when product is updated.
product  output  2*WIDTH  last completed result, registered.

Behaviour:
- Reset (async, any time including mid-RUN): state=IDLE, busy=0, done=0, product=0; M, P, Q, carry and count all cleared. Operation in flight is discarded; no done pulse.
- Internal registers: M (WIDTH), P (WIDTH, upper accumulator), Q (WIDTH, multiplier/lower product), C (1, adder carry), count (CNT_W).
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. start=1 at edge t0 latches M=A, Q=B, P=0, count=0 and moves to RUN.
- RUN (busy=1): the adder computes {Cout,S}=P+M with C0=0. On each edge:
  - If Q[0]=1, {C,P,Q} <= {Cout,S,Q} >> 1.
  - If Q[0]=0, {C,P,Q} <= {1'b0,P,Q} >> 1.
  - count <= count+1.
- RUN timing: iterations occur at edges t1..tWIDTH. On the WIDTH-th iteration edge, the state goes to DONE, product <= the shifted {P,Q} result and done <= 1.
- Latency: product is valid and done is high in the cycle following edge t0+WIDTH, which is 16 cycles for WIDTH=16.
- DONE: done=1 for exactly one cycle and busy=0. Next edge returns to IDLE. If start=1 in DONE, it is accepted like IDLE (back-to-back; goes straight to RUN and done drops).
- start while in RUN is ignored; A/B changes during RUN have no effect.
- product holds its value through IDLE and subsequent RUN until the next completion; it changes only on done.
- Arithmetic: unsigned only. The carry out of the adder is never lost because it is shifted into P[WIDTH-1]. Maximum result is (2^WIDTH-1)^2, which fits in 2*WIDTH bits.
- The adder's internal carry-in is tied to 0. No overflow output exists.

Decomposition:
- Shared package/header: state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
- One sub-module: the existing 16-bit CLA adder, instantiated once as the combinational add stage. The controller, counter and shift registers stay in seq_mult_16bit.

Test Plan:
- A=0, B=0, start pulse -> done after 16 cycles, product=32'h00000000, busy low afterwards.
- A=40000, B=900 -> product=32'h02255100 (36,000,000); done high exactly one cycle.
- A=25937, B=50000 -> product=32'h4D4C5C50 (1,296,850,000); exercises adder carry out on multiple iterations.
- A=65535, B=65535 -> product=32'hFFFE0001; then assert start in the DONE cycle with A=3, B=5 -> second done 16 cycles later with product=32'h0000000F.
- Start A=1000, B=1000, then pulse start with A=2, B=2 at cycle 5 of RUN -> ignored; product=32'h000F4240 (1,000,000).
- Start A=123, B=456, assert rst at cycle 8 of RUN -> busy=0, done=0, product=0 immediately. No done follows; a new start of 7*6 yields product=42 after 16 cycles.
